cnn_conv_acc: RTL and testbench



---
 rtl/cnn_conv_acc_if.sv | 34 +++
 rtl/cnn_conv_acc.sv | 132 +++++++++++++
 tb/tb_cnn_conv_acc.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cnn_conv_acc_if.sv
// -----------------------------------------------------------------------------
// cnn_conv_acc_if
// Handshake bundle between the product stream, the accumulator and the
// feature-map buffer.
//   prod_din/prod_vld/prod_rdy : signed product stream into the accumulator
//   bias                       : per-filter signed bias, at output scale
//   dout/dout_vld/dout_rdy     : activation result stream out of the accumulator
//   busy                       : accumulator holds a partial sum or a pending result
// master = producer/consumer side, slave = accumulator side.
// -----------------------------------------------------------------------------
interface cnn_conv_acc_if #(
   parameter int PROD_W = 24,
   parameter int BIAS_W = 14,
   parameter int OUT_W  = 14
);
   logic [PROD_W-1:0] prod_din;
   logic              prod_vld;
   logic              prod_rdy;
   logic [BIAS_W-1:0] bias;
   logic [OUT_W-1:0]  dout;
   logic              dout_vld;
   logic              dout_rdy;
   logic              busy;

   modport master (
      output prod_din, prod_vld, bias, dout_rdy,
      input  prod_rdy, dout, dout_vld, busy
   );

   modport slave (
      input  prod_din, prod_vld, bias, dout_rdy,
      output prod_rdy, dout, dout_vld, busy
   );
endinterface

// File: rtl/cnn_conv_acc.sv
// -----------------------------------------------------------------------------
// cnn_conv_acc
// Sums TAPS signed products per output pixel on top of a per-filter bias, then
// rounds (half up), shifts out SHIFT fractional bits, applies ReLU and
// saturates to a non-negative OUT_W-bit activation.
//   ap_clk : clock, rising edge
//   ap_rst : synchronous active-high reset
//   bus    : cnn_conv_acc_if.slave (product in, bias, activation out, busy)
// Single-issue: while a result waits in OUT no product is taken.
// -----------------------------------------------------------------------------
module cnn_conv_acc #(
   parameter int PROD_W = 24,
   parameter int ACC_W  = 32,
   parameter int TAPS   = 9,
   parameter int BIAS_W = 14,
   parameter int SHIFT  = 8,
   parameter int OUT_W  = 14
) (
   input  logic          ap_clk,
   input  logic          ap_rst,
   cnn_conv_acc_if.slave bus
);

   localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
   localparam logic signed [ACC_W-1:0] RND_HALF =
      {{(ACC_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic signed [ACC_W-1:0] OUT_MAX =
      {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

   typedef enum logic [0:0] {
      ST_ACC = 1'b0,
      ST_OUT = 1'b1
   } state_t;

   state_t                   r_state;
   state_t                   w_next_state;
   logic [CNT_W-1:0]         r_cnt;
   logic signed [ACC_W-1:0]  r_acc;
   logic [OUT_W-1:0]         r_dout;

   logic                     w_prod_rdy;
   logic                     w_dout_vld;
   logic                     w_accept;
   logic                     w_last;
   logic signed [ACC_W-1:0]  w_bias_ext;
   logic signed [ACC_W-1:0]  w_prod_ext;
   logic signed [ACC_W-1:0]  w_acc_in;
   logic signed [ACC_W-1:0]  w_sum;
   logic signed [ACC_W-1:0]  w_rnd;
   logic signed [ACC_W-1:0]  w_shr;
   logic [OUT_W-1:0]         w_post;

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values of the others, independent of block ordering.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state <= ST_ACC;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every output of this block gets a default first, so no path through
   // the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      w_prod_rdy   = 1'b0;
      w_dout_vld   = 1'b0;
      case (r_state)
         ST_ACC: begin
            w_prod_rdy = 1'b1;
            if (bus.prod_vld && w_last) begin
               w_next_state = ST_OUT;
            end
         end
         ST_OUT: begin
            w_dout_vld = 1'b1;
            if (bus.dout_rdy) begin
               w_next_state = ST_ACC;
            end
         end
         default: w_next_state = ST_ACC;
      endcase
   end

   assign w_accept = bus.prod_vld & w_prod_rdy;
   assign w_last   = (r_cnt == LAST_TAP);

   // ----------------------------------------------------------- datapath
   assign w_bias_ext = {{(ACC_W-BIAS_W){bus.bias[BIAS_W-1]}}, bus.bias} <<< SHIFT;
   assign w_prod_ext = {{(ACC_W-PROD_W){bus.prod_din[PROD_W-1]}}, bus.prod_din};

   // The first tap of a window starts from the scaled bias instead of r_acc;
   // with TAPS = 1 the first tap is also the last, so the same path covers it.
   assign w_acc_in = (r_cnt == '0) ? w_bias_ext : r_acc;
   assign w_sum    = w_acc_in + w_prod_ext;
   assign w_rnd    = w_sum + RND_HALF;
   assign w_shr    = w_rnd >>> SHIFT;

   always_comb begin
      w_post = w_shr[OUT_W-1:0];
      if (w_shr[ACC_W-1]) begin
         w_post = '0;
      end else if (w_shr > OUT_MAX) begin
         w_post = OUT_MAX[OUT_W-1:0];
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_acc  <= '0;
         r_cnt  <= '0;
         r_dout <= '0;
      end else if (w_accept) begin
         r_acc <= w_sum;
         if (w_last) begin
            r_cnt  <= '0;
            r_dout <= w_post;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.prod_rdy = w_prod_rdy;
   assign bus.dout_vld = w_dout_vld;
   assign bus.dout     = r_dout;
   assign bus.busy     = (r_cnt != '0) | w_dout_vld;

endmodule

// File: tb/tb_cnn_conv_acc.sv
// -----------------------------------------------------------------------------
// tb_cnn_conv_acc
// Directed bench for cnn_conv_acc at default parameters. Inputs change and
// outputs are sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_cnn_conv_acc;

   localparam int PROD_W = 24;
   localparam int BIAS_W = 14;
   localparam int OUT_W  = 14;

   typedef struct {
      string                     name;
      logic signed [BIAS_W-1:0]  b;
      logic signed [PROD_W-1:0]  p0;
      logic signed [PROD_W-1:0]  prest;
      logic [OUT_W-1:0]          exp;
   } vec_t;

   logic ap_clk;
   logic ap_rst;
   int   n_checks;
   int   n_fail;
   vec_t vecs[14];

   cnn_conv_acc_if #(.PROD_W(PROD_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) bus ();

   cnn_conv_acc dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus.slave)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drives one full window; first tap carries the bias, later taps present a
   // different bias that must be ignored. Optional random idle gaps.
   task automatic run_window(input string name, input logic signed [BIAS_W-1:0] b,
                             input logic signed [PROD_W-1:0] p0,
                             input logic signed [PROD_W-1:0] prest,
                             input logic [OUT_W-1:0] exp, input bit gaps);
      int n;
      for (int i = 0; i < 9; i++) begin
         if (gaps) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
               bus.prod_vld = 1'b0;
               bus.prod_din = 24'h7fffff;
               bus.bias     = ~b;
               @(negedge ap_clk);
            end
         end
         bus.prod_vld = 1'b1;
         bus.prod_din = (i == 0) ? p0 : prest;
         bus.bias     = (i == 0) ? b : ~b;
         check({name, " prod_rdy"}, 32'(bus.prod_rdy), 32'd1);
         @(negedge ap_clk);
      end
      bus.prod_vld = 1'b0;
      check({name, " dout_vld"}, 32'(bus.dout_vld), 32'd1);
      check({name, " dout"}, 32'(bus.dout), 32'(exp));
      @(negedge ap_clk);
      check({name, " dout_vld one cycle"}, 32'(bus.dout_vld), 32'd0);
      check({name, " busy idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      vecs[0]  = '{"basic",       14'sd0,    24'sd256,     24'sd256,     14'd9};
      vecs[1]  = '{"relu",        14'sd0,    -24'sd1000,   -24'sd1000,   14'd0};
      vecs[2]  = '{"bias only",   14'sd5,    24'sd0,       24'sd0,       14'd5};
      vecs[3]  = '{"round 128",   14'sd0,    24'sd128,     24'sd0,       14'd1};
      vecs[4]  = '{"round 127",   14'sd0,    24'sd127,     24'sd0,       14'd0};
      vecs[5]  = '{"round -128",  14'sd0,    -24'sd128,    24'sd0,       14'd0};
      vecs[6]  = '{"saturate",    14'sd0,    24'sd8388607, 24'sd8388607, 14'd8191};
      vecs[7]  = '{"half up 1.5", 14'sd0,    24'sd384,     24'sd0,       14'd2};
      vecs[8]  = '{"neg bias",    -14'sd3,   24'sd256,     24'sd256,     14'd6};
      vecs[9]  = '{"mixed",       14'sd10,   24'sd1000,    24'sd1000,    14'd45};
      vecs[10] = '{"bias max",    14'sd8191, 24'sd0,       24'sd0,       14'd8191};
      vecs[11] = '{"bias min",    -14'sd8192, 24'sd0,      24'sd0,       14'd0};
      vecs[12] = '{"prod min",    14'sd0,    24'h800000,   24'h800000,   14'd0};
      vecs[13] = '{"half -1.5",   14'sd0,    -24'sd384,    24'sd0,       14'd0};

      ap_rst       = 1'b1;
      bus.prod_vld = 1'b0;
      bus.prod_din = '0;
      bus.bias     = '0;
      bus.dout_rdy = 1'b1;
      repeat (3) @(negedge ap_clk);
      ap_rst = 1'b0;
      @(negedge ap_clk);
      check("reset dout", 32'(bus.dout), 32'd0);
      check("reset dout_vld", 32'(bus.dout_vld), 32'd0);
      check("reset prod_rdy", 32'(bus.prod_rdy), 32'd1);
      check("reset busy", 32'(bus.busy), 32'd0);

      foreach (vecs[k]) begin
         run_window(vecs[k].name, vecs[k].b, vecs[k].p0, vecs[k].prest, vecs[k].exp, 1'b0);
      end

      // Stalled windows must give the same results.
      run_window("gaps basic", 14'sd0, 24'sd256, 24'sd256, 14'd9, 1'b1);
      run_window("gaps mixed", 14'sd10, 24'sd1000, 24'sd1000, 14'd45, 1'b1);

      // Backpressure: result held for 5 cycles while the next product waits.
      bus.dout_rdy = 1'b0;
      for (int i = 0; i < 9; i++) begin
         bus.prod_vld = 1'b1;
         bus.prod_din = 24'sd256;
         bus.bias     = (i == 0) ? 14'sd0 : 14'sd100;
         @(negedge ap_clk);
      end
      bus.prod_din = 24'sd512;   // first product of the next window, held
      bus.bias     = 14'sd0;
      for (int i = 0; i < 5; i++) begin
         check("bp dout_vld", 32'(bus.dout_vld), 32'd1);
         check("bp dout", 32'(bus.dout), 32'd9);
         check("bp prod_rdy", 32'(bus.prod_rdy), 32'd0);
         @(negedge ap_clk);
      end
      bus.dout_rdy = 1'b1;
      @(negedge ap_clk);
      check("bp after xfer dout_vld", 32'(bus.dout_vld), 32'd0);
      check("bp after xfer prod_rdy", 32'(bus.prod_rdy), 32'd1);
      check("bp nothing consumed", 32'(bus.busy), 32'd0);
      @(negedge ap_clk);   // held product 512 accepted at this edge
      check("bp next window started", 32'(bus.busy), 32'd1);
      for (int i = 1; i < 9; i++) begin
         bus.prod_din = 24'sd256;
         bus.bias     = 14'sd50;
         @(negedge ap_clk);
      end
      bus.prod_vld = 1'b0;
      // 512 + 8*256 = 2560, +128 >> 8 = 10
      check("bp next dout_vld", 32'(bus.dout_vld), 32'd1);
      check("bp next dout", 32'(bus.dout), 32'd10);
      @(negedge ap_clk);

      // Reset mid-window discards the partial sum and the captured bias.
      for (int i = 0; i < 4; i++) begin
         bus.prod_vld = 1'b1;
         bus.prod_din = 24'sd1000;
         bus.bias     = 14'sd7;
         @(negedge ap_clk);
      end
      bus.prod_vld = 1'b0;
      check("mid busy before rst", 32'(bus.busy), 32'd1);
      ap_rst = 1'b1;
      @(negedge ap_clk);
      ap_rst = 1'b0;
      check("mid rst busy", 32'(bus.busy), 32'd0);
      check("mid rst prod_rdy", 32'(bus.prod_rdy), 32'd1);
      run_window("after mid rst", 14'sd0, 24'sd256, 24'sd256, 14'd9, 1'b0);

      // Reset while a result is pending drops it; reset wins over dout_rdy.
      bus.dout_rdy = 1'b0;
      for (int i = 0; i < 9; i++) begin
         bus.prod_vld = 1'b1;
         bus.prod_din = 24'sd1000;
         bus.bias     = 14'sd0;
         @(negedge ap_clk);
      end
      bus.prod_vld = 1'b0;
      check("out pending", 32'(bus.dout_vld), 32'd1);
      ap_rst       = 1'b1;
      bus.dout_rdy = 1'b1;
      @(negedge ap_clk);
      ap_rst = 1'b0;
      check("out rst dout_vld", 32'(bus.dout_vld), 32'd0);
      check("out rst dout", 32'(bus.dout), 32'd0);
      check("out rst busy", 32'(bus.busy), 32'd0);
      run_window("after out rst", 14'sd5, 24'sd0, 24'sd0, 14'd5, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
